// File: rtl/gray_counter_bank_if.sv
// Control/read port of gray_counter_bank: per-method enables, channel selects,
// load data, the read mux outputs and the per-channel status vectors.
interface gray_counter_bank_if #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4
);
    localparam int CW = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

    logic                increment__ENA;
    logic [CW-1:0]       increment_chan;
    logic                decrement__ENA;
    logic [CW-1:0]       decrement_chan;
    logic                writeBin__ENA;
    logic [CW-1:0]       writeBin_chan;
    logic [WIDTH-1:0]    writeBin_v;
    logic                writeGray__ENA;
    logic [CW-1:0]       writeGray_chan;
    logic [WIDTH-1:0]    writeGray_v;
    logic                clearFlags__ENA;
    logic [CW-1:0]       read_chan;

    logic [WIDTH-1:0]    readBin;
    logic [WIDTH-1:0]    readGray;
    logic [CHANNELS-1:0] atMax;
    logic [CHANNELS-1:0] atZero;
    logic [CHANNELS-1:0] wrapped;
    logic [CHANNELS-1:0] loadError;
    logic                increment__RDY;
    logic                decrement__RDY;
    logic                writeBin__RDY;
    logic                writeGray__RDY;
    logic                clearFlags__RDY;

    modport master (
        output increment__ENA, increment_chan,
        output decrement__ENA, decrement_chan,
        output writeBin__ENA, writeBin_chan, writeBin_v,
        output writeGray__ENA, writeGray_chan, writeGray_v,
        output clearFlags__ENA, read_chan,
        input  readBin, readGray, atMax, atZero, wrapped, loadError,
        input  increment__RDY, decrement__RDY, writeBin__RDY,
        input  writeGray__RDY, clearFlags__RDY
    );

    modport slave (
        input  increment__ENA, increment_chan,
        input  decrement__ENA, decrement_chan,
        input  writeBin__ENA, writeBin_chan, writeBin_v,
        input  writeGray__ENA, writeGray_chan, writeGray_v,
        input  clearFlags__ENA, read_chan,
        output readBin, readGray, atMax, atZero, wrapped, loadError,
        output increment__RDY, decrement__RDY, writeBin__RDY,
        output writeGray__RDY, clearFlags__RDY
    );
endinterface

// File: rtl/gray_counter_bank.sv
// Bank of independent up/down counters, each holding a binary value and a
// registered Gray image, with wrap or saturate behaviour over MODULUS.
module gray_counter_bank #(
    parameter int WIDTH    = 10,
    parameter int CHANNELS = 4,
    parameter int MODULUS  = 2**WIDTH,
    parameter int SATURATE = 0
) (
    input  logic                CLK,
    input  logic                RST,
    gray_counter_bank_if.slave  bus
);
    localparam int               CW    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;
    localparam bit               SAT   = (SATURATE != 0);
    localparam logic [WIDTH:0]   MOD_W = (WIDTH+1)'(MODULUS);
    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MODULUS - 1);
    localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);

    logic [WIDTH-1:0]    bin_q  [CHANNELS];
    logic [WIDTH-1:0]    gray_q [CHANNELS];
    logic [WIDTH-1:0]    bin_d  [CHANNELS];
    logic [WIDTH-1:0]    load_v [CHANNELS];
    logic [CHANNELS-1:0] wrap_q, lerr_q, wrap_set, lerr_set;
    logic [CHANNELS-1:0] inc_hit, dec_hit, wb_hit, wg_hit, oor;
    logic [WIDTH-1:0]    wg_bin;

    function automatic logic [WIDTH-1:0] gray_to_bin(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b[WIDTH-1] = g[WIDTH-1];
        for (int i = WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

    function automatic logic [WIDTH-1:0] bin_to_gray(input logic [WIDTH-1:0] b);
        return b ^ (b >> 1);
    endfunction

    assign wg_bin = gray_to_bin(bus.writeGray_v);

    // Select values beyond CHANNELS match no channel, so the method is dropped.
    always_comb begin
        inc_hit = '0;
        dec_hit = '0;
        wb_hit  = '0;
        wg_hit  = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            inc_hit[c] = bus.increment__ENA && (bus.increment_chan == CW'(c));
            dec_hit[c] = bus.decrement__ENA && (bus.decrement_chan == CW'(c));
            wb_hit[c]  = bus.writeBin__ENA  && (bus.writeBin_chan  == CW'(c));
            wg_hit[c]  = bus.writeGray__ENA && (bus.writeGray_chan == CW'(c));
            load_v[c]  = wb_hit[c] ? bus.writeBin_v : wg_bin;
        end
    end

    // A full-range modulus can never see an out-of-range load.
    for (genvar g = 0; g < CHANNELS; g++) begin : g_range
        if (MODULUS >= (2**WIDTH)) begin : g_full
            assign oor[g] = 1'b0;
        end else begin : g_part
            assign oor[g] = ({1'b0, load_v[g]} >= MOD_W);
        end
    end

    always_comb begin
        wrap_set = '0;
        lerr_set = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bin_d[c] = bin_q[c];
            if (wb_hit[c] || wg_hit[c]) begin
                if (oor[c]) begin
                    bin_d[c]    = MAX_V;
                    lerr_set[c] = 1'b1;
                end else begin
                    bin_d[c] = load_v[c];
                end
            end else if (inc_hit[c] && !dec_hit[c]) begin
                if (bin_q[c] == MAX_V) begin
                    wrap_set[c] = 1'b1;
                    bin_d[c]    = SAT ? MAX_V : '0;
                end else begin
                    bin_d[c] = bin_q[c] + ONE;
                end
            end else if (dec_hit[c] && !inc_hit[c]) begin
                if (bin_q[c] == '0) begin
                    wrap_set[c] = 1'b1;
                    bin_d[c]    = SAT ? '0 : MAX_V;
                end else begin
                    bin_d[c] = bin_q[c] - ONE;
                end
            end
        end
    end

    // Flag sets in the clearing cycle survive the clear.
    always_ff @(posedge CLK) begin
        if (RST) begin
            for (int c = 0; c < CHANNELS; c++) begin
                bin_q[c]  <= '0;
                gray_q[c] <= '0;
            end
            wrap_q <= '0;
            lerr_q <= '0;
        end else begin
            for (int c = 0; c < CHANNELS; c++) begin
                bin_q[c]  <= bin_d[c];
                gray_q[c] <= bin_to_gray(bin_d[c]);
            end
            wrap_q <= (bus.clearFlags__ENA ? '0 : wrap_q) | wrap_set;
            lerr_q <= (bus.clearFlags__ENA ? '0 : lerr_q) | lerr_set;
        end
    end

    always_comb begin
        bus.readBin  = '0;
        bus.readGray = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (bus.read_chan == CW'(c)) begin
                bus.readBin  = bin_q[c];
                bus.readGray = gray_q[c];
            end
        end
    end

    always_comb begin
        bus.atMax  = '0;
        bus.atZero = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            bus.atMax[c]  = (bin_q[c] == MAX_V);
            bus.atZero[c] = (bin_q[c] == '0);
        end
    end

    assign bus.wrapped         = wrap_q;
    assign bus.loadError       = lerr_q;
    assign bus.increment__RDY  = 1'b1;
    assign bus.decrement__RDY  = 1'b1;
    assign bus.writeBin__RDY   = 1'b1;
    assign bus.writeGray__RDY  = 1'b1;
    assign bus.clearFlags__RDY = 1'b1;
endmodule

// File: tb/tb_gray_counter_bank.sv
// Bench for gray_counter_bank: a wrap-mode bank (MODULUS=16) and a saturate-mode
// bank (MODULUS=10) driven together and compared against an integer model.
module tb_gray_counter_bank;
    typedef struct {
        logic       rst;
        logic       ie;  logic [1:0] ic;
        logic       de;  logic [1:0] dc;
        logic       we;  logic [1:0] wc; logic [3:0] wv;
        logic       ge;  logic [1:0] gc; logic [3:0] gv;
        logic       clr;
        logic [1:0] rc;
    } stim_t;

    logic  CLK = 1'b0;
    stim_t st [2];
    int    mb [2][4];
    bit    mw [2][4];
    bit    ml [2][4];
    int    mod_of [2] = '{16, 10};
    bit    sat_of [2] = '{1'b0, 1'b1};
    int    n_checks = 0;
    int    n_err    = 0;
    bit    chk_on   = 1'b0;

    always #5 CLK = ~CLK;

    gray_counter_bank_if #(.WIDTH(4), .CHANNELS(4)) ifa ();
    gray_counter_bank_if #(.WIDTH(4), .CHANNELS(4)) ifb ();

    gray_counter_bank #(.WIDTH(4), .CHANNELS(4), .MODULUS(16), .SATURATE(0))
        dut_a (.CLK(CLK), .RST(st[0].rst), .bus(ifa));
    gray_counter_bank #(.WIDTH(4), .CHANNELS(4), .MODULUS(10), .SATURATE(1))
        dut_b (.CLK(CLK), .RST(st[1].rst), .bus(ifb));

    assign ifa.increment__ENA  = st[0].ie;  assign ifa.increment_chan = st[0].ic;
    assign ifa.decrement__ENA  = st[0].de;  assign ifa.decrement_chan = st[0].dc;
    assign ifa.writeBin__ENA   = st[0].we;  assign ifa.writeBin_chan  = st[0].wc;
    assign ifa.writeBin_v      = st[0].wv;  assign ifa.writeGray__ENA = st[0].ge;
    assign ifa.writeGray_chan  = st[0].gc;  assign ifa.writeGray_v    = st[0].gv;
    assign ifa.clearFlags__ENA = st[0].clr; assign ifa.read_chan      = st[0].rc;
    assign ifb.increment__ENA  = st[1].ie;  assign ifb.increment_chan = st[1].ic;
    assign ifb.decrement__ENA  = st[1].de;  assign ifb.decrement_chan = st[1].dc;
    assign ifb.writeBin__ENA   = st[1].we;  assign ifb.writeBin_chan  = st[1].wc;
    assign ifb.writeBin_v      = st[1].wv;  assign ifb.writeGray__ENA = st[1].ge;
    assign ifb.writeGray_chan  = st[1].gc;  assign ifb.writeGray_v    = st[1].gv;
    assign ifb.clearFlags__ENA = st[1].clr; assign ifb.read_chan      = st[1].rc;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d, want %0d", name, $time, act, exp);
        end
    endtask

    // Gray decode by search: the value whose Gray image equals g.
    function automatic int g2b(input int g);
        for (int b = 0; b < 16; b++) if ((b ^ (b >> 1)) == g) return b;
        return 0;
    endfunction

    task automatic model_step(input int d);
        bit sw, sl, up, dn, ld;
        int v;
        if (st[d].rst) begin
            for (int c = 0; c < 4; c++) begin mb[d][c] = 0; mw[d][c] = 0; ml[d][c] = 0; end
            return;
        end
        for (int c = 0; c < 4; c++) begin
            sw = 0; sl = 0;
            ld = (st[d].we && int'(st[d].wc) == c) || (st[d].ge && int'(st[d].gc) == c);
            up = st[d].ie && int'(st[d].ic) == c;
            dn = st[d].de && int'(st[d].dc) == c;
            if (ld) begin
                v = (st[d].we && int'(st[d].wc) == c) ? int'(st[d].wv) : g2b(int'(st[d].gv));
                if (v >= mod_of[d]) begin mb[d][c] = mod_of[d] - 1; sl = 1; end
                else mb[d][c] = v;
            end else if (up && !dn) begin
                if (mb[d][c] == mod_of[d] - 1) begin sw = 1; if (!sat_of[d]) mb[d][c] = 0; end
                else mb[d][c]++;
            end else if (dn && !up) begin
                if (mb[d][c] == 0) begin sw = 1; if (!sat_of[d]) mb[d][c] = mod_of[d] - 1; end
                else mb[d][c]--;
            end
            mw[d][c] = (st[d].clr ? 1'b0 : mw[d][c]) | sw;
            ml[d][c] = (st[d].clr ? 1'b0 : ml[d][c]) | sl;
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        model_step(0);
        model_step(1);
        #1;
    endtask

    task automatic compare_dut(input int d, input int rb, input int rg, input int am,
                               input int az, input int wr, input int le, input int rdy);
        int eb, em, ez, ew, el;
        eb = mb[d][int'(st[d].rc)];
        em = 0; ez = 0; ew = 0; el = 0;
        for (int c = 0; c < 4; c++) begin
            if (mb[d][c] == mod_of[d] - 1) em |= (1 << c);
            if (mb[d][c] == 0)             ez |= (1 << c);
            if (mw[d][c])                  ew |= (1 << c);
            if (ml[d][c])                  el |= (1 << c);
        end
        check($sformatf("dut%0d readBin", d), rb, eb);
        check($sformatf("dut%0d readGray", d), rg, eb ^ (eb >> 1));
        check($sformatf("dut%0d atMax", d), am, em);
        check($sformatf("dut%0d atZero", d), az, ez);
        check($sformatf("dut%0d wrapped", d), wr, ew);
        check($sformatf("dut%0d loadError", d), le, el);
        check($sformatf("dut%0d rdy", d), rdy, 31);
    endtask

    always @(negedge CLK) begin
        if (chk_on) begin
            compare_dut(0, int'(ifa.readBin), int'(ifa.readGray), int'(ifa.atMax),
                        int'(ifa.atZero), int'(ifa.wrapped), int'(ifa.loadError),
                        int'({ifa.increment__RDY, ifa.decrement__RDY, ifa.writeBin__RDY,
                              ifa.writeGray__RDY, ifa.clearFlags__RDY}));
            compare_dut(1, int'(ifb.readBin), int'(ifb.readGray), int'(ifb.atMax),
                        int'(ifb.atZero), int'(ifb.wrapped), int'(ifb.loadError),
                        int'({ifb.increment__RDY, ifb.decrement__RDY, ifb.writeBin__RDY,
                              ifb.writeGray__RDY, ifb.clearFlags__RDY}));
        end
    end

    task automatic idle(input int d);
        st[d].ie = 0; st[d].de = 0; st[d].we = 0; st[d].ge = 0; st[d].clr = 0; st[d].rst = 0;
    endtask

    initial begin
        logic [3:0] prev;
        for (int d = 0; d < 2; d++) begin
            st[d] = '{rst: 1'b1, ie: 0, ic: 0, de: 0, dc: 0, we: 0, wc: 0, wv: 0,
                      ge: 0, gc: 0, gv: 0, clr: 0, rc: 0};
        end
        tick(); tick();
        idle(0); idle(1);
        st[0].rc = 2'd1; #1;
        check("reset atZero", int'(ifa.atZero), 15);
        check("reset atMax", int'(ifa.atMax), 0);
        chk_on = 1'b1;

        st[0].ie = 1; st[0].ic = 2'd1;
        repeat (5) tick();
        idle(0); #1;
        check("count5 bin", int'(ifa.readBin), 5);
        check("count5 gray", int'(ifa.readGray), 4'b0111);
        check("count5 atZero", int'(ifa.atZero), 4'b1101);

        st[0].we = 1; st[0].wc = 2'd2; st[0].wv = 4'd15; tick(); idle(0);
        st[0].ie = 1; st[0].ic = 2'd2; tick(); idle(0);
        st[0].rc = 2'd2; #1;
        check("wrap bin", int'(ifa.readBin), 0);
        check("wrap flag", int'(ifa.wrapped[2]), 1);
        st[0].de = 1; st[0].dc = 2'd2; tick(); idle(0); #1;
        check("unwrap bin", int'(ifa.readBin), 15);
        check("unwrap atMax", int'(ifa.atMax[2]), 1);
        st[0].clr = 1; tick(); idle(0); #1;
        check("clear wrapped", int'(ifa.wrapped), 0);

        st[1].we = 1; st[1].wc = 2'd0; st[1].wv = 4'd9; tick(); idle(1);
        st[1].ie = 1; st[1].ic = 2'd0; tick(); idle(1);
        st[1].rc = 2'd0; #1;
        check("sat hold", int'(ifb.readBin), 9);
        check("sat flag", int'(ifb.wrapped[0]), 1);
        st[1].we = 1; st[1].wc = 2'd0; st[1].wv = 4'd12; tick(); idle(1); #1;
        check("sat load clamp", int'(ifb.readBin), 9);
        check("sat loadError", int'(ifb.loadError[0]), 1);

        st[0].we = 1; st[0].wc = 2'd3; st[0].wv = 4'd6; tick(); idle(0);
        st[0].ie = 1; st[0].ic = 2'd3; st[0].de = 1; st[0].dc = 2'd3; tick(); idle(0);
        st[0].rc = 2'd3; #1;
        check("inc+dec cancel", int'(ifa.readBin), 6);
        st[0].ie = 1; st[0].ic = 2'd0; st[0].de = 1; st[0].dc = 2'd1; tick(); idle(0);
        st[0].rc = 2'd0; #1;
        check("inc ch0", int'(ifa.readBin), 1);
        st[0].rc = 2'd1; #1;
        check("dec ch1", int'(ifa.readBin), 4);
        st[0].ge = 1; st[0].gc = 2'd1; st[0].gv = 4'b1100; st[0].ie = 1; st[0].ic = 2'd1;
        tick(); idle(0); #1;
        check("gray load beats inc", int'(ifa.readBin), 8);
        st[0].we = 1; st[0].wc = 2'd2; st[0].wv = 4'd3;
        st[0].ge = 1; st[0].gc = 2'd2; st[0].gv = 4'b1100;
        tick(); idle(0); st[0].rc = 2'd2; #1;
        check("bin beats gray", int'(ifa.readBin), 3);

        st[0].rc = 2'd0; #1;
        prev = ifa.readGray;
        st[0].ie = 1; st[0].ic = 2'd0;
        for (int i = 0; i < 32; i++) begin
            tick();
            check($sformatf("sweep step %0d bits changed", i), $countones(prev ^ ifa.readGray), 1);
            prev = ifa.readGray;
        end
        idle(0);

        st[0].we = 1; st[0].wc = 2'd1; st[0].wv = 4'd7; tick(); idle(0);
        st[0].rc = 2'd1; #1;
        check("preload 7", int'(ifa.readBin), 7);
        st[0].rst = 1; st[0].ie = 1; st[0].ic = 2'd1; tick(); idle(0); #1;
        check("midreset bin", int'(ifa.readBin), 0);
        check("midreset wrapped", int'(ifa.wrapped), 0);
        check("midreset loadError", int'(ifa.loadError), 0);
        check("midreset atZero", int'(ifa.atZero), 15);

        for (int n = 0; n < 3000; n++) begin
            for (int d = 0; d < 2; d++) begin
                st[d].rst = ($urandom_range(0, 99) == 0);
                st[d].ie  = 1'($urandom_range(0, 1)); st[d].ic = 2'($urandom_range(0, 3));
                st[d].de  = 1'($urandom_range(0, 1)); st[d].dc = 2'($urandom_range(0, 3));
                st[d].we  = ($urandom_range(0, 5) == 0);
                st[d].wc  = 2'($urandom_range(0, 3)); st[d].wv = 4'($urandom_range(0, 15));
                st[d].ge  = ($urandom_range(0, 5) == 0);
                st[d].gc  = 2'($urandom_range(0, 3)); st[d].gv = 4'($urandom_range(0, 15));
                st[d].clr = ($urandom_range(0, 9) == 0);
                st[d].rc  = 2'($urandom_range(0, 3));
            end
            tick();
        end
        idle(0); idle(1);
        tick();
        @(negedge CLK); #1;
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
